// File: rtl/note_scheduler.sv
// Shared-tone scheduler: last-pressed key arbitration driving one square-wave divider.
// Optional feature macro: NOTE_SCHED_OCTAVE_EN (adds octave_up, halves the loaded half-period).
`timescale 1ns/1ps
module note_scheduler #(
  parameter int CLK_HZ = 50000000,
  parameter int CNT_W  = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keys,
`ifdef NOTE_SCHED_OCTAVE_EN
  input  logic       octave_up,
`endif
  output logic       tone,
  output logic       active,
  output logic [2:0] note_idx
);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_STOP} state_t;

  function automatic logic [CNT_W-1:0] half_of(input logic [2:0] idx);
    int f;
    case (idx)
      3'd0:    f = 262;
      3'd1:    f = 294;
      3'd2:    f = 330;
      3'd3:    f = 349;
      3'd4:    f = 392;
      3'd5:    f = 440;
      3'd6:    f = 494;
      default: f = 523;
    endcase
    return CNT_W'(CLK_HZ / (2 * f));
  endfunction

  function automatic logic [2:0] msb8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = i[2:0];
    end
    return r;
  endfunction

  logic [7:0]       r_s1, r_s2, r_s3;
  state_t           r_state, w_state_nxt;
  logic             r_tone, w_tone_nxt;
  logic [2:0]       r_note_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_active_half, w_ah_nxt;
  logic [CNT_W-1:0] r_pending, w_pend_nxt;

  logic [7:0]       w_rise, w_held;
  logic [2:0]       w_sel;
  logic             w_oct;
  logic [CNT_W-1:0] w_half, w_load;
  logic             w_term;

  // Stage: key synchronizer plus history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 8'd0;
      r_s2 <= 8'd0;
      r_s3 <= 8'd0;
    end else begin
      r_s1 <= keys;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_held = r_s2;

`ifdef NOTE_SCHED_OCTAVE_EN
  assign w_oct = octave_up;
`else
  assign w_oct = 1'b0;
`endif

  // A new press always wins; otherwise fall back only when the current key was let go.
  always_comb begin
    w_sel = r_note_idx;
    if (|w_rise) begin
      w_sel = msb8(w_rise);
    end else if (!w_held[r_note_idx] && (|w_held)) begin
      w_sel = msb8(w_held);
    end
  end

  assign w_half = half_of(w_sel);
  assign w_load = w_oct ? (w_half >> 1) : w_half;
  assign w_term = (r_cnt == (r_active_half - CNT_W'(1)));

  always_comb begin
    w_state_nxt = r_state;
    w_tone_nxt  = r_tone;
    w_idx_nxt   = r_note_idx;
    w_cnt_nxt   = r_cnt;
    w_ah_nxt    = r_active_half;
    w_pend_nxt  = r_pending;
    case (r_state)
      ST_IDLE: begin
        if (|w_held) begin
          w_state_nxt = ST_PLAY;
          w_idx_nxt   = w_sel;
          w_ah_nxt    = w_load;
          w_pend_nxt  = w_load;
          w_cnt_nxt   = '0;
          w_tone_nxt  = 1'b1;
        end
      end
      ST_PLAY, ST_STOP: begin
        w_idx_nxt  = w_sel;
        w_pend_nxt = w_load;
        // New pitch is adopted only at an edge, so phases are never cut short.
        if (w_term) begin
          w_tone_nxt = ~r_tone;
          w_cnt_nxt  = '0;
          w_ah_nxt   = r_pending;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        if (r_state == ST_PLAY) begin
          if (!(|w_held)) w_state_nxt = ST_STOP;
        end else if (|w_held) begin
          w_state_nxt = ST_PLAY;
        end else if (!r_tone) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_tone_nxt  = 1'b0;
        end else if (w_term) begin
          w_state_nxt = ST_IDLE;
          w_tone_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tone_nxt  = 1'b0;
      end
    endcase
  end

  // Stage: state, divider and selection registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_tone        <= 1'b0;
      r_note_idx    <= 3'd0;
      r_cnt         <= '0;
      r_active_half <= '0;
      r_pending     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_tone        <= w_tone_nxt;
      r_note_idx    <= w_idx_nxt;
      r_cnt         <= w_cnt_nxt;
      r_active_half <= w_ah_nxt;
      r_pending     <= w_pend_nxt;
    end
  end

  assign tone     = r_tone;
  assign active   = (r_state != ST_IDLE);
  assign note_idx = r_note_idx;

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler at CLK_HZ = 1 MHz (C4 1908, G4 1275, A4 1136 cycles/half).
`timescale 1ns/1ps
module tb_note_scheduler;
  localparam int CLK_HZ = 1000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] keys = 8'd0;
  logic       tone;
  logic       active;
  logic [2:0] note_idx;
`ifdef NOTE_SCHED_OCTAVE_EN
  logic       octave_up = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  note_scheduler #(.CLK_HZ(CLK_HZ), .CNT_W(17)) dut (
    .clk      (clk),
    .reset    (reset),
    .keys     (keys),
`ifdef NOTE_SCHED_OCTAVE_EN
    .octave_up(octave_up),
`endif
    .tone     (tone),
    .active   (active),
    .note_idx (note_idx)
  );

  function automatic int half_ref(input int i, input bit oct);
    int freq [8] = '{262, 294, 330, 349, 392, 440, 494, 523};
    int h;
    h = CLK_HZ / (2 * freq[i]);
    return oct ? (h >> 1) : h;
  endfunction

  function automatic int top_bit(input logic [7:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles until tone equals v; -1 if the bound expires.
  task automatic wait_tone(input logic v, input int lim, output int n);
    n = 0;
    while (tone !== v && n < lim) begin
      step(1);
      n++;
    end
    if (tone !== v) n = -1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (active !== 1'b0 && n < 5000) begin
      step(1);
      n++;
    end
    if (active !== 1'b0) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    keys  = 8'd0;
    step(3);
    n_total++;
    if ({tone, active, note_idx} !== 5'b0)
      $display("FAIL reset_hold: tone=%b active=%b idx=%0d want 0/0/0", tone, active, note_idx);
    else n_pass++;
    reset = 1'b0;
    step(100);
    n_total++;
    if ({tone, active, note_idx} !== 5'b0)
      $display("FAIL reset_idle: tone=%b active=%b idx=%0d want 0/0/0", tone, active, note_idx);
    else n_pass++;
  endtask

  task automatic test_single_note();
    int n;
    keys = 8'h10;
    step(2);
    n_total++;
    if (tone !== 1'b0) $display("FAIL press_early: tone=%b want 0", tone);
    else n_pass++;
    step(1);
    n_total++;
    if (tone !== 1'b1 || note_idx !== 3'd4 || active !== 1'b1)
      $display("FAIL press_latency: tone=%b idx=%0d active=%b want 1/4/1", tone, note_idx, active);
    else n_pass++;
    wait_tone(1'b0, 3000, n);
    n_total++;
    if (n != half_ref(4, 0)) $display("FAIL g4_high: got %0d want %0d", n, half_ref(4, 0));
    else n_pass++;
    wait_tone(1'b1, 3000, n);
    n_total++;
    if (n != half_ref(4, 0)) $display("FAIL g4_low: got %0d want %0d", n, half_ref(4, 0));
    else n_pass++;
  endtask

  task automatic test_note_change();
    int n, r;
    r = $urandom_range(20, 600);
    step(r);
    keys = 8'h30;
    step(2);
    n_total++;
    if (note_idx !== 3'd4) $display("FAIL change_early: idx=%0d want 4", note_idx);
    else n_pass++;
    step(1);
    n_total++;
    if (note_idx !== 3'd5) $display("FAIL change_idx: idx=%0d want 5", note_idx);
    else n_pass++;
    wait_tone(1'b0, 3000, n);
    n_total++;
    if (n < 0 || r + 3 + n != half_ref(4, 0))
      $display("FAIL change_old_phase: got %0d want %0d", r + 3 + n, half_ref(4, 0));
    else n_pass++;
    wait_tone(1'b1, 3000, n);
    n_total++;
    if (n != half_ref(5, 0)) $display("FAIL a4_low: got %0d want %0d", n, half_ref(5, 0));
    else n_pass++;
    wait_tone(1'b0, 3000, n);
    n_total++;
    if (n != half_ref(5, 0)) $display("FAIL a4_high: got %0d want %0d", n, half_ref(5, 0));
    else n_pass++;
  endtask

  task automatic test_fallback();
    int n, r;
    r = $urandom_range(20, 600);
    step(r);
    keys = 8'h10;
    step(3);
    n_total++;
    if (note_idx !== 3'd4) $display("FAIL fallback_idx: idx=%0d want 4", note_idx);
    else n_pass++;
    wait_tone(1'b1, 3000, n);
    n_total++;
    if (n < 0 || r + 3 + n != half_ref(5, 0))
      $display("FAIL fallback_old_phase: got %0d want %0d", r + 3 + n, half_ref(5, 0));
    else n_pass++;
    wait_tone(1'b0, 3000, n);
    n_total++;
    if (n != half_ref(4, 0)) $display("FAIL fallback_new_phase: got %0d want %0d", n, half_ref(4, 0));
    else n_pass++;
  endtask

  task automatic test_release();
    int n;
    bit bad;
    keys = 8'd0;
    wait_idle(n);
    n_total++;
    if (n < 0 || tone !== 1'b0) $display("FAIL idle_reach: n=%0d tone=%b want idle tone 0", n, tone);
    else n_pass++;
    step(5);
    keys = 8'h01;
    step(3);
    n_total++;
    if (tone !== 1'b1 || note_idx !== 3'd0)
      $display("FAIL c4_start: tone=%b idx=%0d want 1/0", tone, note_idx);
    else n_pass++;
    step(300);
    keys = 8'd0;
    step(3);
    n_total++;
    if (active !== 1'b1 || tone !== 1'b1)
      $display("FAIL stop_phase: active=%b tone=%b want 1/1", active, tone);
    else n_pass++;
    wait_tone(1'b0, 3000, n);
    n_total++;
    if (n < 0 || 303 + n != half_ref(0, 0) || active !== 1'b0)
      $display("FAIL release_finish: len=%0d active=%b want %0d/0", 303 + n, active, half_ref(0, 0));
    else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (tone !== 1'b0 || active !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL idle_quiet: tone/active toggled after release, want 0");
    else n_pass++;
  endtask

  task automatic test_reset_mid_note();
    int n;
    keys = 8'h10;
    step(3 + $urandom_range(50, 900));
    reset = 1'b1;
    step(1);
    n_total++;
    if ({tone, active, note_idx} !== 5'b0)
      $display("FAIL reset_mid: tone=%b active=%b idx=%0d want 0/0/0", tone, active, note_idx);
    else n_pass++;
    reset = 1'b0;
    step(3);
    n_total++;
    if (tone !== 1'b1 || note_idx !== 3'd4)
      $display("FAIL reset_replay: tone=%b idx=%0d want 1/4", tone, note_idx);
    else n_pass++;
    keys = 8'd0;
    wait_idle(n);
    n_total++;
    if (n < 0) $display("FAIL reset_idle_wait: active=%b want 0", active);
    else n_pass++;
  endtask

  // Random key vectors checked against the last-pressed rule applied to whole vectors.
  task automatic test_random_keys();
    logic [7:0] k, nk, rise;
    int exp_idx, n, n2;
    logic t;
    k = 8'd0;
    exp_idx = 0;
    for (int it = 0; it < 24; it++) begin
      if (k != 8'd0 && $urandom_range(0, 1) == 1) nk = k & 8'($urandom_range(0, 255));
      else nk = 8'($urandom_range(1, 255));
      if (nk == 8'd0) nk = k;
      rise = nk & ~k;
      if (rise != 8'd0) exp_idx = top_bit(rise);
      else if (!nk[exp_idx]) exp_idx = top_bit(nk);
      keys = nk;
      k = nk;
      step(3);
      n_total++;
      if (note_idx !== 3'(exp_idx) || active !== 1'b1)
        $display("FAIL rand_idx[%0d]: keys=%h idx=%0d active=%b want %0d/1", it, nk, note_idx, active, exp_idx);
      else n_pass++;
      if (it % 4 == 3) begin
        t = tone;
        wait_tone(~t, 4000, n);
        wait_tone(t, 4000, n2);
        n_total++;
        if (n < 0 || n2 != half_ref(exp_idx, 0))
          $display("FAIL rand_phase[%0d]: got %0d want %0d", it, n2, half_ref(exp_idx, 0));
        else n_pass++;
      end
    end
    keys = 8'd0;
    wait_idle(n);
    n_total++;
    if (n < 0) $display("FAIL rand_idle_wait: active=%b want 0", active);
    else n_pass++;
  endtask

`ifdef NOTE_SCHED_OCTAVE_EN
  task automatic test_octave();
    int n;
    octave_up = 1'b1;
    keys = 8'h10;
    step(3);
    wait_tone(1'b0, 3000, n);
    n_total++;
    if (n != half_ref(4, 1)) $display("FAIL oct_high: got %0d want %0d", n, half_ref(4, 1));
    else n_pass++;
    wait_tone(1'b1, 3000, n);
    n_total++;
    if (n != half_ref(4, 1)) $display("FAIL oct_low: got %0d want %0d", n, half_ref(4, 1));
    else n_pass++;
    octave_up = 1'b0;
    wait_tone(1'b0, 3000, n);
    wait_tone(1'b1, 3000, n);
    n_total++;
    if (n != half_ref(4, 0)) $display("FAIL oct_off: got %0d want %0d", n, half_ref(4, 0));
    else n_pass++;
    keys = 8'd0;
    wait_idle(n);
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_note();
    test_note_change();
    test_fallback();
    test_release();
    test_reset_mid_note();
    test_random_keys();
`ifdef NOTE_SCHED_OCTAVE_EN
    test_octave();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
